// File: rtl/ula_pkg.sv
// Shared opcode constants and FSM state encoding for the 8-bit sequential ALU
// and its 4-bit ALU slice.
package ula_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_NOTA = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLo   = 2'b01,
        StHi   = 2'b10,
        StDone = 2'b11
    } state_e;

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/ula.sv
// 4-bit combinational ALU slice: AND, OR, NOT A, NAND and ADD with carry.
// Any other selector yields a zero result and zero carry.
module ula
    import ula_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] sel,
    input  logic       cin,
    output logic [3:0] y,
    output logic       cout
);

    logic [4:0] sum;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        y    = 4'h0;
        cout = 1'b0;
        case (sel)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOTA: y = ~a;
            OP_NAND: y = ~(a & b);
            OP_ADD: begin
                y    = sum[3:0];
                cout = sum[4];
            end
            default: begin
                y    = 4'h0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_seq8.sv
// 8-bit ALU built from one time-shared 4-bit slice: low nibble pass, then high
// nibble pass with the stored carry, then a held result until handshake.
module ula_seq8
    import ula_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [2:0] in_op,
    input  logic       in_cin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic       out_cout,
    output logic [7:0] op_count
);

    state_e     state_q, state_d;
    logic [7:0] a_q, b_q;
    logic [2:0] op_q;
    logic       cin_q;
    logic       carry_q;
    logic [3:0] lo_q;

    logic       is_sub, is_arith, hi_pass;
    logic [3:0] nib_b;
    logic [3:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_sel;
    logic       alu_cin, alu_cout;

    // SUB reuses the adder: A + ~B + 1 per byte, carry chained through carry_q.
    always_comb begin
        is_sub   = (op_q == OP_SUB);
        is_arith = is_arith_op(op_q);
        hi_pass  = (state_q == StHi);
        alu_sel  = is_sub ? OP_ADD : op_q;
        alu_a    = hi_pass ? a_q[7:4] : a_q[3:0];
        nib_b    = hi_pass ? b_q[7:4] : b_q[3:0];
        alu_b    = is_sub ? ~nib_b : nib_b;
        if (!is_arith) begin
            alu_cin = 1'b0;
        end else if (hi_pass) begin
            alu_cin = carry_q;
        end else if (is_sub) begin
            alu_cin = 1'b1;
        end else begin
            alu_cin = cin_q;
        end
    end

    ula u_ula (
        .a    (alu_a),
        .b    (alu_b),
        .sel  (alu_sel),
        .cin  (alu_cin),
        .y    (alu_y),
        .cout (alu_cout)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        case (state_q)
            StIdle: if (in_valid) state_d = StLo;
            StLo:   state_d = StHi;
            StHi:   state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            op_q       <= 3'b000;
            cin_q      <= 1'b0;
            carry_q    <= 1'b0;
            lo_q       <= 4'h0;
            out_result <= 8'h00;
            out_cout   <= 1'b0;
            op_count   <= 8'h00;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        op_q  <= in_op;
                        cin_q <= in_cin;
                    end
                end
                StLo: begin
                    lo_q    <= alu_y;
                    carry_q <= alu_cout;
                end
                StHi: begin
                    out_result <= {alu_y, lo_q};
                    out_cout   <= is_arith & alu_cout;
                end
                StDone: begin
                    if (out_ready) op_count <= op_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
